// File: rtl/mms_stream.sv
// Streaming min/max selector: reduces each frame of up to SIZE unsigned beats
// to its maximum or minimum, with the winner's position and the frame length.
module mms_stream #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 8,
    parameter int IDXW  = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [IDXW-1:0]  result_idx,
    output logic [IDXW:0]    result_len
);

    typedef enum logic {
        ACC,
        OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDXW:0]    cnt;
    logic             sel_q;
    logic [WIDTH-1:0] best;
    logic [IDXW-1:0]  best_idx;

    logic             accept;
    logic             first;
    logic             better;
    logic             last_beat;
    logic [WIDTH-1:0] beat_best;
    logic [IDXW-1:0]  beat_idx;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == OUT);
    assign accept    = in_valid && in_ready;
    assign first     = (cnt == '0);

    // Strict comparison only, so on ties the earliest position is kept.
    assign better    = sel_q ? (in_data < best) : (in_data > best);
    assign beat_best = (first || better) ? in_data : best;
    assign beat_idx  = first ? '0 : (better ? cnt[IDXW-1:0] : best_idx);
    assign last_beat = in_last || (cnt == (IDXW+1)'(SIZE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACC:     if (accept && last_beat) state_next = OUT;
            OUT:     if (out_ready) state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    // Running best is updated on every accepted beat; the terminating beat's
    // comparison is folded straight into the registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            sel_q      <= 1'b0;
            best       <= '0;
            best_idx   <= '0;
            result     <= '0;
            result_idx <= '0;
            result_len <= '0;
        end else if (accept) begin
            if (first) begin
                sel_q <= select;
            end
            best     <= beat_best;
            best_idx <= beat_idx;
            if (last_beat) begin
                cnt        <= '0;
                result     <= beat_best;
                result_idx <= beat_idx;
                result_len <= cnt + (IDXW+1)'(1);
            end else begin
                cnt <= cnt + (IDXW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_mms_stream.sv
// Randomized and directed bench for mms_stream, checked against a reference
// model that finds the extreme value and its first occurrence directly.
module tb_mms_stream;

    localparam int WIDTH = 8;
    localparam int SIZE  = 8;
    localparam int IDXW  = $clog2(SIZE);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             select;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [IDXW-1:0]  result_idx;
    logic [IDXW:0]    result_len;

    int tests_run;
    int tests_failed;

    logic [WIDTH-1:0] frame [SIZE];
    int               frame_len;
    logic             frame_sel;
    logic             frame_last;
    logic             frame_bubbles;

    mms_stream #(.WIDTH(WIDTH), .SIZE(SIZE), .IDXW(IDXW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .select     (select),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .result_idx (result_idx),
        .result_len (result_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: the extreme value of the frame, then its first position.
    task automatic modelFrame(output logic [WIDTH-1:0] exp_val, output int exp_idx);
        int ext;
        ext = frame[0];
        for (int i = 1; i < frame_len; i++) begin
            if (frame_sel == 1'b0 && int'(frame[i]) > ext) ext = frame[i];
            if (frame_sel == 1'b1 && int'(frame[i]) < ext) ext = frame[i];
        end
        exp_idx = -1;
        for (int i = frame_len - 1; i >= 0; i--) begin
            if (int'(frame[i]) == ext) exp_idx = i;
        end
        exp_val = ext[WIDTH-1:0];
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic sendBeat(input logic [WIDTH-1:0] d, input logic last, input logic sel);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        select   = sel;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < frame_len; i++) begin
            if (frame_bubbles) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            if (i == frame_len - 1 && frame_len > 1) begin
                check("out_valid_before_last", 32'(out_valid), 32'd0);
            end
            sendBeat(frame[i], (i == frame_len - 1) ? frame_last : 1'b0,
                     (i == 0) ? frame_sel : ~frame_sel);
        end
    endtask

    task automatic checkOutput(input string tag, input int hold_cycles);
        logic [WIDTH-1:0] exp_val;
        int               exp_idx;
        modelFrame(exp_val, exp_idx);
        check({tag, "_valid"},    32'(out_valid),  32'd1);
        check({tag, "_result"},   32'(result),     32'(exp_val));
        check({tag, "_idx"},      32'(result_idx), 32'(exp_idx));
        check({tag, "_len"},      32'(result_len), 32'(frame_len));
        check({tag, "_in_ready"}, 32'(in_ready),   32'd0);
        for (int c = 0; c < hold_cycles; c++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'($urandom);
            in_last  = 1'($urandom);
            @(negedge clk);
            check({tag, "_hold_valid"},    32'(out_valid),  32'd1);
            check({tag, "_hold_result"},   32'(result),     32'(exp_val));
            check({tag, "_hold_idx"},      32'(result_idx), 32'(exp_idx));
            check({tag, "_hold_len"},      32'(result_len), 32'(frame_len));
            check({tag, "_hold_in_ready"}, 32'(in_ready),   32'd0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drained_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_drained_ready"}, 32'(in_ready),  32'd1);
    endtask

    task automatic loadFrame(input logic [WIDTH-1:0] d [SIZE], input int len,
                             input logic sel, input logic last);
        for (int i = 0; i < SIZE; i++) frame[i] = d[i];
        frame_len     = len;
        frame_sel     = sel;
        frame_last    = last;
        frame_bubbles = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] d [SIZE];

        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_last      = 1'b0;
        select       = 1'b0;
        out_ready    = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_in_ready",  32'(in_ready),   32'd1);
        check("reset_out_valid", 32'(out_valid),  32'd0);
        check("reset_result",    32'(result),     32'd0);
        check("reset_idx",       32'(result_idx), 32'd0);
        check("reset_len",       32'(result_len), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        d = '{8'd3, 8'd200, 8'd17, 8'd200, 8'd5, 8'd0, 8'd99, 8'd1};
        loadFrame(d, 8, 1'b0, 1'b0);
        applyStimulus();
        checkOutput("max_full", 0);

        d = '{8'd50, 8'd7, 8'd80, 8'd7, 8'd255, 8'd9, 8'd7, 8'd60};
        loadFrame(d, 8, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("min_full", 0);

        d = '{8'd10, 8'd40, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        loadFrame(d, 3, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("short", 0);

        d = '{8'hAA, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        loadFrame(d, 1, 1'b1, 1'b1);
        applyStimulus();
        checkOutput("single", 0);

        d = '{8'd9, 8'd1, 8'd250, 8'd4, 8'd250, 8'd2, 8'd6, 8'd8};
        loadFrame(d, 8, 1'b0, 1'b1);
        applyStimulus();
        checkOutput("backpressure", 5);

        d = '{8'd5, 8'd3, 8'd9, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0};
        loadFrame(d, 4, 1'b1, 1'b1);
        applyStimulus();
        checkOutput("after_bp", 0);

        // Reset while holding a nonzero result, then reset mid-frame.
        d = '{8'd1, 8'd77, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        loadFrame(d, 3, 1'b0, 1'b1);
        applyStimulus();
        check("pre_reset_result", 32'(result), 32'd77);
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid),  32'd0);
        check("rst_result",    32'(result),     32'd0);
        check("rst_idx",       32'(result_idx), 32'd0);
        check("rst_len",       32'(result_len), 32'd0);
        check("rst_in_ready",  32'(in_ready),   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) sendBeat(8'(i + 1), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_result",    32'(result),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        d = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        loadFrame(d, 8, 1'b1, 1'b0);
        applyStimulus();
        checkOutput("all_ff_min", 0);

        d = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        loadFrame(d, 8, 1'b0, 1'b0);
        frame_bubbles = 1'b1;
        applyStimulus();
        checkOutput("bubbles", 0);

        for (int f = 0; f < 40; f++) begin
            frame_len     = $urandom_range(1, SIZE);
            frame_sel     = 1'($urandom);
            frame_bubbles = 1'($urandom);
            frame_last    = (frame_len < SIZE) ? 1'b1 : 1'($urandom);
            for (int i = 0; i < SIZE; i++) begin
                frame[i] = (f % 2 == 0) ? WIDTH'($urandom_range(0, 7)) : WIDTH'($urandom);
            end
            applyStimulus();
            checkOutput("random", $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
